// File: rtl/uc_escalonador_frame.sv
// Per-frame task scheduler: each accepted frame tick runs four game tasks in order
// (shots, asteroids, collision, render), one start pulse at a time, under a watchdog.
module uc_escalonador_frame #(
  parameter int TIMEOUT         = 1000,
  parameter int LARGURA_TIMEOUT = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       pausar,
  input  logic       tick_frame,
  input  logic [3:0] fim_tarefa,
  output logic [3:0] inicia_tarefa,
  output logic       ocupado,
  output logic       frame_perdido,
  output logic       erro_timeout,
  output logic [7:0] contador_frames,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    inicial     = 4'h0,
    espera_tick = 4'h1,
    dispara     = 4'h2,
    aguarda     = 4'h3,
    proxima     = 4'h4,
    fim_frame   = 4'h5,
    pausado     = 4'h6,
    erro        = 4'hF
  } estado_t;

  localparam logic [LARGURA_TIMEOUT-1:0] WD_LIMITE = LARGURA_TIMEOUT'(TIMEOUT - 1);

  estado_t                    estado_r;
  estado_t                    proximo_s;
  logic [1:0]                 idx_r;
  logic [LARGURA_TIMEOUT-1:0] wd_r;
  logic [7:0]                 contador_r;
  logic                       ocupado_s;

  // Next-state logic; pause and iniciar are only looked at between frames
  always_comb begin
    proximo_s = estado_r;
    case (estado_r)
      inicial: begin
        if (iniciar) proximo_s = espera_tick;
        else         proximo_s = inicial;
      end
      espera_tick: begin
        if (!iniciar)        proximo_s = inicial;
        else if (pausar)     proximo_s = pausado;
        else if (tick_frame) proximo_s = dispara;
        else                 proximo_s = espera_tick;
      end
      dispara: proximo_s = aguarda;
      aguarda: begin
        // a done on the last watchdog cycle still beats the trap
        if (fim_tarefa[idx_r])      proximo_s = proxima;
        else if (wd_r == WD_LIMITE) proximo_s = erro;
        else                        proximo_s = aguarda;
      end
      proxima: begin
        if (idx_r == 2'd3) proximo_s = fim_frame;
        else               proximo_s = dispara;
      end
      fim_frame: begin
        if (pausar) proximo_s = pausado;
        else        proximo_s = espera_tick;
      end
      pausado: begin
        if (pausar) proximo_s = pausado;
        else        proximo_s = espera_tick;
      end
      erro:    proximo_s = erro;
      default: proximo_s = erro;
    endcase
  end

  // State register plus task index, watchdog and frame counter updates
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_r   <= inicial;
      idx_r      <= 2'd0;
      wd_r       <= '0;
      contador_r <= 8'd0;
    end else begin
      estado_r <= proximo_s;
      case (estado_r)
        espera_tick: begin
          if (proximo_s == dispara) idx_r <= 2'd0;
        end
        dispara: wd_r <= '0;
        aguarda: begin
          if (!fim_tarefa[idx_r] && (wd_r != WD_LIMITE)) wd_r <= wd_r + 1'b1;
        end
        proxima: begin
          if (idx_r != 2'd3) idx_r <= idx_r + 2'd1;
        end
        fim_frame: contador_r <= contador_r + 8'd1;
        default: ;
      endcase
    end
  end

  // Moore decode from the registered state; only the drop flag also sees the tick
  always_comb begin
    inicia_tarefa = 4'b0000;
    ocupado_s     = 1'b0;
    erro_timeout  = 1'b0;
    case (estado_r)
      dispara: begin
        inicia_tarefa = 4'b0001 << idx_r;
        ocupado_s     = 1'b1;
      end
      aguarda, proxima, fim_frame: ocupado_s = 1'b1;
      erro:    erro_timeout = 1'b1;
      default: ocupado_s = 1'b0;
    endcase
  end

  assign ocupado         = ocupado_s;
  assign frame_perdido   = ocupado_s & tick_frame;
  assign db_estado       = estado_r;
  assign contador_frames = contador_r;

endmodule

// File: doc/uc_escalonador_frame.md
# uc_escalonador_frame

Per-frame task scheduler for the game loop. Each accepted frame tick runs four game tasks in a fixed order, one at a time: shot update, asteroid update, collision check, render. Each task gets a one-cycle start pulse, and the next task starts only after the current one reports done. The block sits between the frame counter (its `rco` is `tick_frame`) and the task control units. It also counts completed frames, flags dropped ticks and traps hung tasks with a watchdog.

## Interface
Parameters:
- `TIMEOUT`, default 1000: number of cycles a task may stay in `aguarda` without a done pulse before the block traps to `erro`.
- `LARGURA_TIMEOUT`, default 10: watchdog counter width. Must satisfy 2^`LARGURA_TIMEOUT` ≥ `TIMEOUT`.

Ports (one clock; reset is synchronous and active-high):
- `clock`  in  1  system clock, all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `iniciar`  in  1  level; game running.
- `pausar`  in  1  level; pause request.
- `tick_frame`  in  1  one-cycle frame pulse.
- `fim_tarefa`  in  4  done pulses. [0] shots, [1] asteroids, [2] collision, [3] render.
- `inicia_tarefa`  out  4  one-hot, one-cycle start pulse, same bit order as `fim_tarefa`.
- `ocupado`  out  1  a frame is in progress.
- `frame_perdido`  out  1  one-cycle pulse: a tick arrived while busy.
- `erro_timeout`  out  1  high while in `erro`.
- `contador_frames`  out  8  completed frames, mod 256.
- `db_estado`  out  4  state code.

## Operation
- Internal registers: state; task index `idx` (2 bits); watchdog `wd`; `contador_frames`.
- States and `db_estado` codes: `inicial` 0, `espera_tick` 1, `dispara` 2, `aguarda` 3, `proxima` 4, `fim_frame` 5, `pausado` 6, `erro` F. Any unlisted encoding goes to `erro`.
- `inicial`: go to `espera_tick` when `iniciar`=1.
- `espera_tick`, in priority order:
  - `iniciar`=0: go to `inicial`.
  - `pausar`=1: go to `pausado`.
  - `tick_frame`=1: set `idx`=0 and go to `dispara`.
- `dispara`:
  - `inicia_tarefa[idx]`=1; all other bits 0.
  - Clear `wd`.
  - Go to `aguarda`.
- `aguarda`, in priority order:
  - `fim_tarefa[idx]`=1: go to `proxima`.
  - `wd`=`TIMEOUT`-1: go to `erro`.
  - Otherwise increment `wd`.
  - `fim_tarefa` bits other than `idx` are ignored.
- `proxima`:
  - `idx`=3: go to `fim_frame`.
  - Otherwise increment `idx` and go to `dispara`.
- `fim_frame`:
  - Increment `contador_frames`; 255 wraps to 0.
  - Go to `pausado` if `pausar`=1, else to `espera_tick`.
- `pausado`: go to `espera_tick` when `pausar`=0.
- `erro`: absorbing; only `reset` leaves it.
- Pause is never honoured mid-frame. A frame that has started always runs all four tasks, then pauses. `iniciar` is also ignored mid-frame.
- Dropped ticks:
  - `tick_frame`=1 in `dispara`, `aguarda`, `proxima` or `fim_frame` raises `frame_perdido` for one cycle (the same cycle, combinational from the registered state). The tick is discarded, not queued.
  - Ticks in `inicial`, `pausado` or `erro` are ignored silently.
- Output decoding:
  - `ocupado`=1 in `dispara`, `aguarda`, `proxima` and `fim_frame`.
  - `erro_timeout`=1 only in `erro`.
  - All outputs except `contador_frames` are decoded Moore-style from state; `frame_perdido` also uses `tick_frame`.

## Timing
- Reset: state `inicial`, `idx`=0, `wd`=0, `contador_frames`=0. All outputs are 0, including `db_estado`=0. `reset` overrides everything, including in `erro` and mid-frame.
- Tick sampled in `espera_tick` at cycle t: `inicia_tarefa`=0001 during t+1.
- A done pulse is accepted no earlier than the cycle after its start pulse. A done pulse in the same cycle as the start pulse is lost.
- With every done pulse arriving at the earliest legal cycle:
  - Each task takes 3 cycles.
  - Start pulses appear at t+1, t+4, t+7 and t+10.
  - `fim_frame` at t+13.
  - `contador_frames` updated and state back in `espera_tick` at t+14.
  - A tick at t+14 is accepted.
- Watchdog: the trap happens after exactly `TIMEOUT` consecutive `aguarda` cycles without the matching done. `erro_timeout` rises on the next cycle.
- A done pulse on the final watchdog cycle wins over the timeout.

## Test plan
- Reset, `iniciar`=1, one tick at cycle t, each `fim_tarefa` bit pulsed one cycle after its start: `inicia_tarefa` = 0001/0010/0100/1000 at t+1/t+4/t+7/t+10; `contador_frames`=1 and `ocupado`=0 at t+14.
- Tick pulsed during task 2's `aguarda`: `frame_perdido`=1 for exactly that cycle; frame completes normally; count increments by 1 only.
- `pausar`=1 raised at t+5, mid-frame: all four tasks still run; state `pausado` (`db_estado`=6); ticks ignored; on `pausar`=0, back to `espera_tick`.
- `TIMEOUT`=8, task 1 never done: `erro_timeout`=1 and `db_estado`=F at 8 cycles after the `aguarda` entry; synchronous `reset` returns all outputs to 0.
- Wrong done bit: `fim_tarefa`=0100 while `idx`=0 is ignored; the block advances only on 0001.
- Run 256 frames: `contador_frames` wraps 255 → 0.
